// File: rtl/dac_pkg.sv
// Shared definitions for the sample-stream DAC path: sample width, sample type
// and the PWM period helper used by the generators and the PWM stage.
package dac_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Number of ticks in one PWM period for a w-bit counter.
  function automatic int unsigned PWM_PERIOD(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: asserts tick once every PRESCALE clk cycles (always, for PRESCALE=1).
module pwm_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_pre_cnt;
  logic          w_tick;

  // With PRESCALE=1 the counter sits at 0 == LAST, so tick stays high.
  assign w_tick = (r_pre_cnt == LAST);
  assign tick   = w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: takes one sample per PWM period through a one-entry holding register
// and drives a registered 1-bit PWM output; flags periods that start without data.
module pwm_dac
  import dac_pkg::*;
#(
  parameter int WIDTH    = SAMPLE_W,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic             underrun
);

  // Last counter value of a period; the counter never reaches 2^WIDTH-1.
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PWM_PERIOD(WIDTH) - 1);

  logic             w_tick;
  logic             w_boundary;
  logic             w_accept;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_hold;
  logic             r_full;
  logic             r_pwm;
  logic             r_period_start;
  logic             r_underrun;

  pwm_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_boundary   = w_tick && (r_cnt == CNT_LAST);
  assign sample_ready = !r_full && !rst;
  assign w_accept     = sample_valid && sample_ready;

  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign underrun     = r_underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_duty         <= '0;
      r_hold         <= '0;
      r_full         <= 1'b0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      if (w_tick) begin
        r_cnt <= w_boundary ? '0 : r_cnt + 1'b1;
      end

      r_period_start <= w_boundary;
      r_underrun     <= w_boundary && !r_full;

      // Load and accept are exclusive: accept needs the holding register empty.
      if (w_boundary && r_full) begin
        r_duty <= r_hold;
        r_full <= 1'b0;
      end
      if (w_accept) begin
        r_hold <= sample_in;
        r_full <= 1'b1;
      end

      r_pwm <= (r_cnt < r_duty);
    end
  end

endmodule

// File: doc/pwm_dac.md
# pwm_dac

Converts the 8-bit sample stream from the waveform generators (triangle, and siblings) into a 1-bit PWM signal for the board's RC-filtered DAC pin. Sits directly downstream of the generator stage. Accepts one sample per PWM period through a valid/ready handshake with a one-entry holding register. Reports underrun when the upstream stage fails to supply a sample in time.

## Interface
Parameters:
- WIDTH, 8: sample width; PWM period is 2^WIDTH-1 ticks (255).
- PRESCALE, 1: clk cycles per PWM tick; legal range is ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sample_in  in  WIDTH  sample value (unsigned)
- sample_valid  in  1  sample_in is valid this cycle
- sample_ready  out  1  holding register empty; sample accepted when valid&&ready
- pwm_out  out  1  PWM output, registered
- period_start  out  1  one-clk pulse on the cycle a new duty is loaded
- underrun  out  1  one-clk pulse when a period starts with holding empty

## Operation
- Prescaler: pre_cnt counts 0..PRESCALE-1. tick=1 when pre_cnt==PRESCALE-1, then pre_cnt wraps to 0. With PRESCALE=1, tick is always 1.
- Period counter: cnt (WIDTH bits) advances on each tick, 0..2^WIDTH-2, then wraps to 0.
- Boundary = tick with cnt==2^WIDTH-2.
- At a boundary with holding full: duty<=holding, holding becomes empty, period_start=1.
- At a boundary with holding empty: duty keeps its old value, period_start=1, underrun=1.
- Accept: sample_ready = !full && !rst. On valid&&ready, holding<=sample_in and full<=1.
- Accept on the boundary cycle while holding is empty: the sample goes to holding, not to duty. underrun is still asserted, and that sample is loaded at the next boundary.
- Accept never happens while full, because sample_ready=0. The upstream stage must hold sample_in and sample_valid until the sample is accepted.
- pwm_out<=(cnt<duty), evaluated every clk. duty=0 gives always low. duty=255 gives always high (255/255). Otherwise the output is high for duty ticks of each period.
- All compares are unsigned, WIDTH bits. No arithmetic overflow is possible, because cnt never reaches 2^WIDTH-1.

## Timing
- Reset values:
  - pre_cnt=0, cnt=0, duty=0, full=0.
  - pwm_out=0, period_start=0, underrun=0.
  - sample_ready=0 while rst is high; it goes to 1 on the first cycle after rst deasserts.
- Reset mid-operation clears all state at the next clk edge, including any pending sample, which is discarded.
- pwm_out lags cnt/duty by 1 clk.
- period_start and underrun are registered and high on the clk after the boundary edge. That is the same cycle in which cnt reads 0 with the new duty.
- Sample-to-output latency: from acceptance to the next boundary, plus 1 clk. Maximum (2^WIDTH-1)·PRESCALE+1 clk.
- Throughput: at most one sample per PWM period. sample_ready rises the clk after a boundary load.

## Structure
- Shared package dac_pkg:
  - SAMPLE_W=8
  - function/constant PWM_PERIOD(w)=2^w-1
  - typedef sample_t (logic [SAMPLE_W-1:0]), reused by the waveform generators.
- One sub-module, pwm_tick_gen (prescaler): parameter PRESCALE; ports clk, rst, tick.
- The counter, holding register and compare logic stay in pwm_dac.

## Test plan
- Reset/idle, PRESCALE=1, no samples: pwm_out=0 throughout. underrun pulses every 255 clk. sample_ready=1 after reset.
- Duty sweep: feed 0, then 255, then 128, each before its boundary. The matching periods read 0, 255 and 128 high clk out of 255. Exactly one period_start per period.
- Back-pressure: hold sample_valid=1 with sequential values. Exactly one accept per 255 clk. sample_ready stays 0 while full. No value is lost or duplicated.
- Boundary race: assert valid on the boundary cycle with holding empty. underrun=1. The sample takes effect one period later.
- Reset mid-period with duty=200 and holding full: pwm_out=0 and sample_ready=0 during rst. After release, duty=0 and the pending sample is gone.
- PRESCALE=4, duty=64: period=1020 clk, pwm_out high for 256 clk, period_start every 1020 clk.
